jtkiwi_sndctl: RTL and testbench

Parametrised sound-CPU glue controller for the Kiwi-family sound subsystem, sitting between the sound Z80 (devwait wrapper) and its ROM, shared RAM, YM2203 and cabinet inputs. It generalises the existing inline logic to a configurable ROM bank width, FM wait length and cabinet port count. It adds a working watchdog cleared by bank-register writes and a VBL interrupt latch with defined set/clear priority.

---
 rtl/jtkiwi_sndctl_if.sv | 23 ++
 rtl/jtkiwi_sndctl.sv | 164 ++++++++++++++++
 tb/tb_jtkiwi_sndctl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtkiwi_sndctl_if.sv
// Sound Z80 bus as seen by the Kiwi sound glue controller.
// master = CPU/devwait side, slave = glue controller.
interface jtkiwi_sndctl_if;
  logic [15:0] A;
  logic        mreq_n;
  logic        rfsh_n;
  logic        iorq_n;
  logic        wr_n;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        int_n;
  logic        dev_busy;

  modport master (
    output A, mreq_n, rfsh_n, iorq_n, wr_n, cpu_dout,
    input  cpu_din, int_n, dev_busy
  );

  modport slave (
    input  A, mreq_n, rfsh_n, iorq_n, wr_n, cpu_dout,
    output cpu_din, int_n, dev_busy
  );
endinterface

// File: rtl/jtkiwi_sndctl.sv
// Kiwi-family sound CPU glue: address decode, ROM banking, FM wait,
// cabinet ports, VBL interrupt latch and frame watchdog.
module jtkiwi_sndctl #(
  parameter int unsigned BANKW       = 2,
  parameter int unsigned FM_WAIT     = 1,
  parameter int unsigned NCAB        = 3,
  parameter int unsigned WDOG_FRAMES = 8,
  parameter int unsigned WDOG_PULSE  = 16
) (
  input  logic                  clk,
  input  logic                  comb_rstn,
  input  logic                  cen6,
  jtkiwi_sndctl_if.slave        bus,
  input  logic                  LVBL,
  input  logic                  mshramen,
  input  logic [7:0]            rom_data,
  input  logic [7:0]            ram_dout,
  input  logic [7:0]            fm_dout,
  input  logic [8*NCAB-1:0]     cab_in,
  output logic [14+BANKW-1:0]   rom_addr,
  output logic                  rom_cs,
  output logic                  bank_cs,
  output logic                  fm_cs,
  output logic                  cab_cs,
  output logic                  ram_cs,
  output logic [BANKW-1:0]      bank,
  output logic                  mcu_rst,
  output logic                  wdog_rst
);

  localparam int unsigned ROMW = 14 + BANKW;

  logic       mem_acc;
  logic       irq_ack;
  logic       vbl_fall;
  logic       lvbl_l;
  logic       fmcs_l;
  logic [3:0] fm_cnt;
  logic       fm_busy;
  logic [7:0] cab_sel;
  logic [7:0] cab_dout;
  logic [7:0] din;
  logic       int_r;
  logic       unused_wr;

  // Write strobe is not needed: the bank latch follows its chip select.
  assign unused_wr = bus.wr_n;

  assign mem_acc  = ~bus.mreq_n & bus.rfsh_n;
  assign irq_ack  = ~bus.iorq_n;
  assign vbl_fall = lvbl_l & ~LVBL;

  assign rom_addr = bus.A[15] ? {1'b1, bank, bus.A[12:0]} : ROMW'(bus.A[14:0]);

  assign bus.cpu_din  = din;
  assign bus.int_n    = int_r;
  assign fm_busy      = fm_cnt != 4'd0;
  assign bus.dev_busy = (mshramen & ram_cs) | fm_busy;

  // Cabinet port selected by A[2:0]; unpopulated ports read as zero.
  always_comb begin
    cab_sel = 8'h00;
    for (int unsigned k = 0; k < NCAB; k++) begin
      if (bus.A[2:0] == 3'(k)) cab_sel = cab_in[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      rom_cs   <= 1'b0;
      bank_cs  <= 1'b0;
      fm_cs    <= 1'b0;
      cab_cs   <= 1'b0;
      ram_cs   <= 1'b0;
      cab_dout <= 8'h00;
      din      <= 8'h00;
    end else begin
      rom_cs   <= mem_acc && (bus.A[15:12] < 4'hA);
      bank_cs  <= mem_acc && (bus.A[15:12] == 4'hA);
      fm_cs    <= mem_acc && (bus.A[15:12] == 4'hB);
      cab_cs   <= mem_acc && (bus.A[15:12] == 4'hC);
      ram_cs   <= mem_acc && ((bus.A[15:12] == 4'hD) || (bus.A[15:12] == 4'hE));
      cab_dout <= cab_sel;
      if (rom_cs)      din <= rom_data;
      else if (ram_cs) din <= ram_dout;
      else if (fm_cs)  din <= fm_dout;
      else if (cab_cs) din <= cab_dout;
      else             din <= 8'h00;
    end
  end

  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      bank    <= '0;
      mcu_rst <= 1'b0;
    end else if (bank_cs) begin
      bank    <= bus.cpu_dout[BANKW-1:0];
      mcu_rst <= bus.cpu_dout[BANKW];
    end
  end

  // FM wait: a fresh FM select holds the CPU for FM_WAIT cen6 ticks.
  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      fmcs_l <= 1'b0;
      fm_cnt <= 4'd0;
    end else if (cen6) begin
      fmcs_l <= fm_cs;
      if (fm_cs && !fmcs_l)  fm_cnt <= 4'(FM_WAIT);
      else if (fm_busy)      fm_cnt <= fm_cnt - 4'd1;
    end
  end

  // VBL interrupt latch; a new frame edge beats a simultaneous acknowledge.
  always_ff @(posedge clk or negedge comb_rstn) begin
    if (!comb_rstn) begin
      lvbl_l <= 1'b1;
      int_r  <= 1'b1;
    end else begin
      lvbl_l <= LVBL;
      if (vbl_fall)     int_r <= 1'b0;
      else if (irq_ack) int_r <= 1'b1;
    end
  end

  generate
    if (WDOG_FRAMES > 0) begin : g_wdog
      localparam int unsigned FW = $clog2(WDOG_FRAMES + 1);
      localparam int unsigned PW = (WDOG_PULSE > 1) ? $clog2(WDOG_PULSE) : 1;

      logic [FW-1:0] frames;
      logic [PW-1:0] pulse_cnt;
      logic          pulse;
      logic          timeout;

      // Frame count, cleared by any bank write, fires on the last frame.
      assign timeout  = !bank_cs && vbl_fall && (frames == FW'(WDOG_FRAMES - 1));
      assign wdog_rst = pulse;

      always_ff @(posedge clk or negedge comb_rstn) begin
        if (!comb_rstn) begin
          frames    <= '0;
          pulse_cnt <= '0;
          pulse     <= 1'b0;
        end else begin
          if (bank_cs || timeout) frames <= '0;
          else if (vbl_fall)      frames <= frames + FW'(1);

          if (timeout) begin
            pulse     <= 1'b1;
            pulse_cnt <= PW'(WDOG_PULSE - 1);
          end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - PW'(1);
          end else begin
            pulse     <= 1'b0;
          end
        end
      end
    end else begin : g_no_wdog
      assign wdog_rst = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_jtkiwi_sndctl.sv
// Bench for jtkiwi_sndctl: spec-level reference model compared every cycle,
// plus literal expectations taken from hand-worked bus sequences.
module tb_jtkiwi_sndctl;

  localparam int unsigned BANKW = 2;
  localparam int unsigned FMW   = 3;
  localparam int unsigned NCAB  = 3;
  localparam int unsigned WF    = 2;
  localparam int unsigned WP    = 16;

  logic        clk = 1'b0;
  logic        comb_rstn;
  logic        cen6;
  logic        LVBL;
  logic        mshramen;
  logic [7:0]  rom_data, ram_dout, fm_dout;
  logic [23:0] cab_in;
  logic [15:0] rom_addr;
  logic        rom_cs, bank_cs, fm_cs, cab_cs, ram_cs;
  logic [1:0]  bank;
  logic        mcu_rst, wdog_rst;

  jtkiwi_sndctl_if bus();

  jtkiwi_sndctl #(
    .BANKW(BANKW), .FM_WAIT(FMW), .NCAB(NCAB), .WDOG_FRAMES(WF), .WDOG_PULSE(WP)
  ) dut (
    .clk(clk), .comb_rstn(comb_rstn), .cen6(cen6), .bus(bus),
    .LVBL(LVBL), .mshramen(mshramen), .rom_data(rom_data), .ram_dout(ram_dout),
    .fm_dout(fm_dout), .cab_in(cab_in), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .bank_cs(bank_cs), .fm_cs(fm_cs), .cab_cs(cab_cs), .ram_cs(ram_cs),
    .bank(bank), .mcu_rst(mcu_rst), .wdog_rst(wdog_rst)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state of the sound glue described by its rules.
  logic       e_rom_cs, e_bank_cs, e_fm_cs, e_cab_cs, e_ram_cs;
  logic [7:0] e_din, e_cab;
  logic [1:0] e_bank;
  logic       e_mcu, irq_pend, vbl_prev, fm_prev, fall;
  int         fm_left, frames, pulse_end, cyc, page, idx;
  logic       acc;
  logic [15:0] e_addr;

  always @(posedge clk or negedge comb_rstn) begin
    cyc++;
    if (!comb_rstn) begin
      {e_rom_cs, e_bank_cs, e_fm_cs, e_cab_cs, e_ram_cs} = 5'b0;
      e_din = 8'h00; e_cab = 8'h00; e_bank = 2'd0; e_mcu = 1'b0;
      irq_pend = 1'b0; vbl_prev = 1'b1; fm_prev = 1'b0;
      fm_left = 0; frames = 0; pulse_end = 0;
    end else begin
      fall = vbl_prev && !LVBL;
      e_din = e_rom_cs ? rom_data : e_ram_cs ? ram_dout : e_fm_cs ? fm_dout :
              e_cab_cs ? e_cab : 8'h00;
      if (e_bank_cs) begin
        e_bank = bus.cpu_dout[1:0];
        e_mcu  = bus.cpu_dout[2];
      end
      if (e_bank_cs) frames = 0;
      else if (fall) begin
        frames++;
        if (frames == int'(WF)) begin
          frames = 0;
          pulse_end = cyc + int'(WP);
        end
      end
      if (cen6) begin
        if (e_fm_cs && !fm_prev) fm_left = int'(FMW);
        else if (fm_left > 0)    fm_left--;
        fm_prev = e_fm_cs;
      end
      if (fall) irq_pend = 1'b1;
      else if (!bus.iorq_n) irq_pend = 1'b0;
      vbl_prev = LVBL;
      page = int'(bus.A) / 4096;
      acc  = !bus.mreq_n && bus.rfsh_n;
      e_rom_cs  = acc && page < 10;
      e_bank_cs = acc && page == 10;
      e_fm_cs   = acc && page == 11;
      e_cab_cs  = acc && page == 12;
      e_ram_cs  = acc && (page == 13 || page == 14);
      idx   = int'(bus.A) % 8;
      e_cab = (idx < int'(NCAB)) ? 8'(cab_in >> (8 * idx)) : 8'h00;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      e_addr = bus.A[15] ? (16'h8000 | (16'(e_bank) << 13) | (bus.A & 16'h1FFF))
                         : (bus.A & 16'h7FFF);
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("rom_cs",   32'(rom_cs),   32'(e_rom_cs));
      chk("bank_cs",  32'(bank_cs),  32'(e_bank_cs));
      chk("fm_cs",    32'(fm_cs),    32'(e_fm_cs));
      chk("cab_cs",   32'(cab_cs),   32'(e_cab_cs));
      chk("ram_cs",   32'(ram_cs),   32'(e_ram_cs));
      chk("cpu_din",  32'(bus.cpu_din), 32'(e_din));
      chk("bank",     32'(bank),     32'(e_bank));
      chk("mcu_rst",  32'(mcu_rst),  32'(e_mcu));
      chk("int_n",    32'(bus.int_n), 32'(!irq_pend));
      chk("dev_busy", 32'(bus.dev_busy), 32'((mshramen && e_ram_cs) || fm_left > 0));
      chk("wdog_rst", 32'(wdog_rst), 32'(cyc < pulse_end));
    end
  end

  initial begin
    cen6 = 1'b0;
    forever begin
      @(posedge clk);
      #2 cen6 = ~cen6;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bank_write(input logic [7:0] d);
    bus.A = 16'hA000; bus.cpu_dout = d; bus.mreq_n = 1'b0;
    tick(2);
    bus.mreq_n = 1'b1; bus.A = 16'h0000;
    tick(1);
  endtask

  task automatic count_wdog(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      tick(1);
      if (wdog_rst) hi++;
    end
  endtask

  logic [15:0] cab_a [4];
  logic [7:0]  cab_e [4];
  int          cnt;

  initial begin
    cab_a = '{16'hC000, 16'hC001, 16'hC002, 16'hC005};
    cab_e = '{8'h81, 8'h22, 8'h0F, 8'h00};
    cyc = 0;
    comb_rstn = 1'b0;
    bus.A = 16'h0000; bus.mreq_n = 1'b1; bus.rfsh_n = 1'b1; bus.iorq_n = 1'b1;
    bus.wr_n = 1'b1; bus.cpu_dout = 8'h00;
    LVBL = 1'b1; mshramen = 1'b0;
    rom_data = 8'h11; ram_dout = 8'h33; fm_dout = 8'h5A; cab_in = 24'h0F2281;
    tick(3);
    comb_rstn = 1'b1;
    cmp_en = 1'b1;
    tick(1);
    chk("rst_int_n", 32'(bus.int_n), 32'd1);
    chk("rst_bank", 32'(bank), 32'd0);
    chk("rst_din", 32'(bus.cpu_din), 32'h00);
    chk("rst_wdog", 32'(wdog_rst), 32'd0);

    // Bank mapping
    bus.wr_n = 1'b0;
    bank_write(8'h07);
    bus.wr_n = 1'b1;
    chk("bank_val", 32'(bank), 32'd3);
    chk("mcu_rst_val", 32'(mcu_rst), 32'd1);
    bus.A = 16'h8123; #1;
    chk("rom_addr_banked", 32'(rom_addr), 32'hE123);
    bus.A = 16'h4123; #1;
    chk("rom_addr_low", 32'(rom_addr), 32'h4123);
    bus.mreq_n = 1'b0; tick(2);
    chk("rom_read", 32'(bus.cpu_din), 32'h11);
    bus.mreq_n = 1'b1; tick(2);

    // FM wait: 3 cen6 ticks at one cen6 per two clk
    bus.A = 16'hB001; bus.mreq_n = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick(1);
      if (bus.dev_busy) cnt++;
    end
    chk("fm_busy_clks", 32'(cnt), 32'd6);
    chk("fm_read", 32'(bus.cpu_din), 32'h5A);
    bus.mreq_n = 1'b1; tick(4);

    // Shared RAM
    mshramen = 1'b1; bus.A = 16'hD010; bus.mreq_n = 1'b0; tick(2);
    chk("ram_busy", 32'(bus.dev_busy), 32'd1);
    bus.mreq_n = 1'b1; tick(2);
    chk("ram_idle", 32'(bus.dev_busy), 32'd0);
    mshramen = 1'b0; bus.mreq_n = 1'b0; tick(2);
    chk("ram_nobusy", 32'(bus.dev_busy), 32'd0);
    chk("ram_read", 32'(bus.cpu_din), 32'h33);
    bus.mreq_n = 1'b1; tick(2);

    // Cabinet ports
    for (int i = 0; i < 4; i++) begin
      bus.A = cab_a[i]; bus.mreq_n = 1'b0; tick(2);
      chk("cab_read", 32'(bus.cpu_din), 32'(cab_e[i]));
      bus.mreq_n = 1'b1; tick(1);
    end

    // IRQ latch
    LVBL = 1'b0; tick(1);
    chk("irq_set", 32'(bus.int_n), 32'd0);
    LVBL = 1'b1; bus.iorq_n = 1'b0; tick(1);
    chk("irq_ack", 32'(bus.int_n), 32'd1);
    bus.iorq_n = 1'b1; tick(1);
    LVBL = 1'b0; bus.iorq_n = 1'b0; tick(1);
    chk("irq_set_wins", 32'(bus.int_n), 32'd0);
    bus.iorq_n = 1'b1; LVBL = 1'b1;
    tick(20);
    bus.iorq_n = 1'b0; tick(1); bus.iorq_n = 1'b1; tick(1);

    // Watchdog: two frames without a bank write
    bank_write(8'h07);
    LVBL = 1'b0; tick(1);
    LVBL = 1'b1; tick(2);
    chk("wdog_one_frame", 32'(wdog_rst), 32'd0);
    LVBL = 1'b0;
    count_wdog(30, cnt);
    chk("wdog_pulse_len", 32'(cnt), 32'd16);

    // Bank write between the frames keeps it quiet
    LVBL = 1'b1; tick(1);
    LVBL = 1'b0; tick(1);
    LVBL = 1'b1;
    bank_write(8'h07);
    LVBL = 1'b0;
    count_wdog(30, cnt);
    chk("wdog_kicked", 32'(cnt), 32'd0);

    // Reset in the middle of a pulse with an IRQ pending
    bank_write(8'h07);
    LVBL = 1'b1; tick(1);
    LVBL = 1'b0; tick(1);
    LVBL = 1'b1; tick(1);
    LVBL = 1'b0; tick(3);
    chk("wdog_mid_pulse", 32'(wdog_rst), 32'd1);
    comb_rstn = 1'b0; #1;
    chk("rst_wdog_async", 32'(wdog_rst), 32'd0);
    chk("rst_int_async", 32'(bus.int_n), 32'd1);
    chk("rst_bank_async", 32'(bank), 32'd0);
    chk("rst_mcu_async", 32'(mcu_rst), 32'd0);
    tick(2);
    comb_rstn = 1'b1; tick(2);
    chk("wdog_after_rst", 32'(wdog_rst), 32'd0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
